rx_signal_frame_ctrl: RTL and testbench

Parametrised receive-side frame controller for the 802.11a bit path. It sits after the Viterbi decoder and before the descrambler. It captures and validates the 24-bit SIGNAL field, then computes N_SYM, N_DATA and pad count internally, so no `num_pads` input is needed. It then streams the DATA field downstream with a valid/ready handshake, tagging each bit as SERVICE/PSDU/TAIL/PAD and flagging the last bit of the frame.

---
 rtl/rx80211a_pkg.sv | 59 +++++
 rtl/rx_symbol_calc.sv | 53 +++++
 rtl/rx_signal_frame_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_rx_signal_frame_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx80211a_pkg.sv
// Shared definitions for the 802.11a receive bit path: states, rate table,
// field tags, error codes and SIGNAL field bit positions.
package rx80211a_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_CHECK,
        ST_CALC,
        ST_DATA
    } state_t;

    localparam logic [3:0] RATE_6M  = 4'b1101;
    localparam logic [3:0] RATE_9M  = 4'b1111;
    localparam logic [3:0] RATE_12M = 4'b0101;
    localparam logic [3:0] RATE_18M = 4'b0111;
    localparam logic [3:0] RATE_24M = 4'b1001;
    localparam logic [3:0] RATE_36M = 4'b1011;
    localparam logic [3:0] RATE_48M = 4'b0001;
    localparam logic [3:0] RATE_54M = 4'b0011;

    localparam logic [1:0] FIELD_SERVICE = 2'd0;
    localparam logic [1:0] FIELD_PSDU    = 2'd1;
    localparam logic [1:0] FIELD_TAIL    = 2'd2;
    localparam logic [1:0] FIELD_PAD     = 2'd3;

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_PARITY = 2'd1;
    localparam logic [1:0] ERR_RATE   = 2'd2;
    localparam logic [1:0] ERR_LENGTH = 2'd3;

    localparam int SIG_RATE_LSB = 0;
    localparam int SIG_RESERVED = 4;
    localparam int SIG_LEN_LSB  = 5;
    localparam int SIG_LEN_MSB  = 16;
    localparam int SIG_PARITY   = 17;
    localparam int SIG_TAIL_LSB = 18;
    localparam int SIG_TAIL_MSB = 23;
    localparam int SIG_BITS     = 24;

    localparam int SERVICE_BITS = 16;
    localparam int TAIL_BITS    = 6;

    // Zero marks an illegal rate code.
    function automatic logic [7:0] rate_to_ndbps(input logic [3:0] code);
        case (code)
            RATE_6M:  return 8'd24;
            RATE_9M:  return 8'd36;
            RATE_12M: return 8'd48;
            RATE_18M: return 8'd72;
            RATE_24M: return 8'd96;
            RATE_36M: return 8'd144;
            RATE_48M: return 8'd192;
            RATE_54M: return 8'd216;
            default:  return 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/rx_symbol_calc.sv
// Iterative symbol calculator: adds N_DBPS once per cycle until the running
// total covers SERVICE+PSDU+TAIL, giving N_SYM, N_DATA and the pad count.
module rx_symbol_calc #(
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             clear,
    input  logic             start,
    input  logic [7:0]       ndbps,
    input  logic [CNT_W-1:0] need,
    output logic             done,
    output logic [CNT_W-1:0] n_sym,
    output logic [CNT_W-1:0] n_data,
    output logic [7:0]       num_pads
);

    logic             running;
    logic [CNT_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       ndbps_r;
    logic [CNT_W-1:0] need_r;
    logic [CNT_W-1:0] acc_next;

    // done is combinational so the caller sees it in the same cycle as the last add.
    assign acc_next = acc + CNT_W'(ndbps_r);
    assign done     = running && (acc_next >= need_r);
    assign n_sym    = cnt + CNT_W'(1);
    assign n_data   = acc_next;
    assign num_pads = 8'(acc_next - need_r);

    always_ff @(posedge Clk) begin
        if (Reset || clear) begin
            running <= 1'b0;
            acc     <= '0;
            cnt     <= '0;
            ndbps_r <= '0;
            need_r  <= '0;
        end else if (start) begin
            running <= 1'b1;
            acc     <= '0;
            cnt     <= '0;
            ndbps_r <= ndbps;
            need_r  <= need;
        end else if (running) begin
            acc <= acc_next;
            cnt <= cnt + CNT_W'(1);
            if (done)
                running <= 1'b0;
        end
    end

endmodule

// File: rtl/rx_signal_frame_ctrl.sv
// Receive frame controller: captures and validates SIGNAL, sizes the DATA
// field, then streams tagged DATA bits to the descrambler.
module rx_signal_frame_ctrl
    import rx80211a_pkg::*;
#(
    parameter int LEN_W        = 12,
    parameter int CNT_W        = 16,
    parameter int PARITY_CHECK = 1,
    parameter int TAIL_CHECK   = 0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             abort,
    input  logic             frame_start,
    input  logic             in_bit,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_bit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_field,
    output logic             out_last,
    output logic [3:0]       rate,
    output logic [LEN_W-1:0] length,
    output logic [CNT_W-1:0] n_sym,
    output logic [7:0]       num_pads,
    output logic             hdr_valid,
    output logic             hdr_error,
    output logic [1:0]       err_code,
    output logic             busy
);

    state_t           state;
    logic [4:0]       bit_cnt;
    logic [23:0]      sig;
    logic [CNT_W-1:0] need_r;
    logic [CNT_W-1:0] n_data_r;
    logic [CNT_W-1:0] data_cnt;

    logic [3:0]       rate_field;
    logic [LEN_W-1:0] len_field;
    logic [CNT_W-1:0] need_field;
    logic [7:0]       ndbps;
    logic             parity_bad;
    logic             rate_bad;
    logic             len_bad;
    logic             calc_start;
    logic             calc_done;
    logic [CNT_W-1:0] calc_n_sym;
    logic [CNT_W-1:0] calc_n_data;
    logic [7:0]       calc_pads;
    logic [1:0]       field_tag;
    logic             accept;

    // R1 arrives first and lands in the MSB of the rate code.
    assign rate_field = {sig[SIG_RATE_LSB], sig[SIG_RATE_LSB+1], sig[SIG_RATE_LSB+2], sig[SIG_RATE_LSB+3]};
    assign len_field  = LEN_W'(sig[SIG_LEN_MSB:SIG_LEN_LSB]);
    assign need_field = CNT_W'(SERVICE_BITS + TAIL_BITS) + (CNT_W'(len_field) << 3);
    assign ndbps      = rate_to_ndbps(rate_field);
    assign parity_bad = (PARITY_CHECK != 0) && (^sig[SIG_PARITY:0]);
    assign rate_bad   = (ndbps == 8'd0);
    assign len_bad    = (len_field == '0) || sig[SIG_RESERVED] ||
                        ((TAIL_CHECK != 0) && (sig[SIG_TAIL_MSB:SIG_TAIL_LSB] != '0));
    assign calc_start = (state == ST_CHECK) && !abort && !parity_bad && !rate_bad && !len_bad;

    assign in_ready = (state == ST_HDR) || ((state == ST_DATA) && (!out_valid || out_ready));
    assign accept   = in_valid && in_ready;
    assign busy     = (state != ST_IDLE);

    always_comb begin
        field_tag = FIELD_PAD;
        if (data_cnt < CNT_W'(SERVICE_BITS))
            field_tag = FIELD_SERVICE;
        else if (data_cnt < need_r - CNT_W'(TAIL_BITS))
            field_tag = FIELD_PSDU;
        else if (data_cnt < need_r)
            field_tag = FIELD_TAIL;
    end

    rx_symbol_calc #(.CNT_W(CNT_W)) u_calc (
        .Clk      (Clk),
        .Reset    (Reset),
        .clear    (abort),
        .start    (calc_start),
        .ndbps    (ndbps),
        .need     (need_field),
        .done     (calc_done),
        .n_sym    (calc_n_sym),
        .n_data   (calc_n_data),
        .num_pads (calc_pads)
    );

    // The output register drains in every state; abort drops it outright.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            sig       <= '0;
            need_r    <= '0;
            n_data_r  <= '0;
            data_cnt  <= '0;
            out_bit   <= 1'b0;
            out_valid <= 1'b0;
            out_field <= FIELD_SERVICE;
            out_last  <= 1'b0;
            rate      <= '0;
            length    <= '0;
            n_sym     <= '0;
            num_pads  <= '0;
            hdr_valid <= 1'b0;
            hdr_error <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            hdr_valid <= 1'b0;
            hdr_error <= 1'b0;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            if (abort) begin
                state     <= ST_IDLE;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (frame_start) begin
                            state    <= ST_HDR;
                            bit_cnt  <= '0;
                            err_code <= ERR_NONE;
                        end
                    end
                    ST_HDR: begin
                        if (in_valid) begin
                            sig[bit_cnt] <= in_bit;
                            bit_cnt      <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'(SIG_BITS - 1))
                                state <= ST_CHECK;
                        end
                    end
                    ST_CHECK: begin
                        rate   <= rate_field;
                        length <= len_field;
                        need_r <= need_field;
                        if (parity_bad) begin
                            hdr_error <= 1'b1;
                            err_code  <= ERR_PARITY;
                            state     <= ST_IDLE;
                        end else if (rate_bad) begin
                            hdr_error <= 1'b1;
                            err_code  <= ERR_RATE;
                            state     <= ST_IDLE;
                        end else if (len_bad) begin
                            hdr_error <= 1'b1;
                            err_code  <= ERR_LENGTH;
                            state     <= ST_IDLE;
                        end else begin
                            state <= ST_CALC;
                        end
                    end
                    ST_CALC: begin
                        if (calc_done) begin
                            n_sym     <= calc_n_sym;
                            num_pads  <= calc_pads;
                            n_data_r  <= calc_n_data;
                            data_cnt  <= '0;
                            hdr_valid <= 1'b1;
                            state     <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (accept) begin
                            out_bit   <= in_bit;
                            out_valid <= 1'b1;
                            out_field <= field_tag;
                            out_last  <= (data_cnt == n_data_r - CNT_W'(1));
                            data_cnt  <= data_cnt + CNT_W'(1);
                            if (data_cnt == n_data_r - CNT_W'(1))
                                state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rx_signal_frame_ctrl.sv
// Scoreboard bench for rx_signal_frame_ctrl: stimulus pushes expected header
// results and DATA bits into queues, a negedge monitor pops and compares.
module tb_rx_signal_frame_ctrl;

    typedef struct {
        logic       b;
        logic [1:0] f;
        logic       last;
    } exp_bit_t;

    typedef struct {
        int         nsym;
        int         pads;
        logic [3:0] rate;
        int         len;
        int         cyc;
    } exp_hdr_t;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        abort = 1'b0;
    logic        frame_start = 1'b0;
    logic        in_bit = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;

    logic        in_ready, out_bit, out_valid, out_last, hdr_valid, hdr_error, busy;
    logic [1:0]  out_field, err_code;
    logic [3:0]  rate;
    logic [11:0] length;
    logic [15:0] n_sym;
    logic [7:0]  num_pads;

    logic        np_in_ready, np_out_bit, np_out_valid, np_out_last, np_hdr_valid, np_hdr_error, np_busy;
    logic [1:0]  np_out_field, np_err_code;
    logic [3:0]  np_rate;
    logic [11:0] np_length;
    logic [15:0] np_n_sym;
    logic [7:0]  np_num_pads;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int last_accept_cyc = 0;
    int np_valid_cnt = 0;
    int np_err_cnt = 0;
    bit bp_mode = 1'b0;

    exp_bit_t   data_q[$];
    exp_hdr_t   hdr_q[$];
    logic [1:0] err_q[$];

    rx_signal_frame_ctrl dut (
        .Clk(Clk), .Reset(Reset), .abort(abort), .frame_start(frame_start),
        .in_bit(in_bit), .in_valid(in_valid), .in_ready(in_ready),
        .out_bit(out_bit), .out_valid(out_valid), .out_ready(out_ready),
        .out_field(out_field), .out_last(out_last), .rate(rate), .length(length),
        .n_sym(n_sym), .num_pads(num_pads), .hdr_valid(hdr_valid),
        .hdr_error(hdr_error), .err_code(err_code), .busy(busy)
    );

    // Second instance with parity checking disabled, driven by the same inputs.
    rx_signal_frame_ctrl #(.PARITY_CHECK(0)) dut_np (
        .Clk(Clk), .Reset(Reset), .abort(abort), .frame_start(frame_start),
        .in_bit(in_bit), .in_valid(in_valid), .in_ready(np_in_ready),
        .out_bit(np_out_bit), .out_valid(np_out_valid), .out_ready(out_ready),
        .out_field(np_out_field), .out_last(np_out_last), .rate(np_rate), .length(np_length),
        .n_sym(np_n_sym), .num_pads(np_num_pads), .hdr_valid(np_hdr_valid),
        .hdr_error(np_hdr_error), .err_code(np_err_code), .busy(np_busy)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge Clk);
            #1;
            out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: compares whatever the DUT presents against the queues.
    initial begin
        logic pv_stall, pv_bit, pv_last, pv_intr;
        logic [1:0] pv_field;
        exp_bit_t e;
        exp_hdr_t h;
        logic [1:0] ec;
        pv_stall = 1'b0; pv_bit = 1'b0; pv_last = 1'b0; pv_intr = 1'b0; pv_field = 2'd0;
        forever begin
            @(negedge Clk);
            if (pv_stall && !pv_intr) begin
                check_output("stall out_valid", 32'(out_valid), 32'd1);
                check_output("stall out_bit", 32'(out_bit), 32'(pv_bit));
                check_output("stall out_field", 32'(out_field), 32'(pv_field));
                check_output("stall out_last", 32'(out_last), 32'(pv_last));
            end
            pv_stall = out_valid && !out_ready;
            pv_bit   = out_bit;
            pv_field = out_field;
            pv_last  = out_last;
            pv_intr  = abort || Reset;
            if (out_valid && out_ready) begin
                if (data_q.size() == 0) begin
                    check_output("unexpected out_valid", 32'd1, 32'd0);
                end else begin
                    e = data_q.pop_front();
                    check_output("out_bit", 32'(out_bit), 32'(e.b));
                    check_output("out_field", 32'(out_field), 32'(e.f));
                    check_output("out_last", 32'(out_last), 32'(e.last));
                end
            end
            if (hdr_valid) begin
                if (hdr_q.size() == 0) begin
                    check_output("unexpected hdr_valid", 32'd1, 32'd0);
                end else begin
                    h = hdr_q.pop_front();
                    check_output("n_sym", 32'(n_sym), h.nsym);
                    check_output("num_pads", 32'(num_pads), h.pads);
                    check_output("rate", 32'(rate), 32'(h.rate));
                    check_output("length", 32'(length), h.len);
                    check_output("hdr_valid cycle", cyc, h.cyc);
                end
            end
            if (hdr_error) begin
                if (err_q.size() == 0) begin
                    check_output("unexpected hdr_error", 32'd1, 32'd0);
                end else begin
                    ec = err_q.pop_front();
                    check_output("err_code", 32'(err_code), 32'(ec));
                end
            end
            if (np_hdr_valid) np_valid_cnt++;
            if (np_hdr_error) np_err_cnt++;
        end
    end

    task automatic apply_stimulus(input logic b, input bit rand_valid);
        bit done;
        int guard;
        done = 1'b0;
        guard = 0;
        while (!done) begin
            in_bit   = b;
            in_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge Clk);
            if (in_valid && in_ready) done = 1'b1;
            @(posedge Clk);
            #1;
            if (done) last_accept_cyc = cyc;
            guard++;
            if (!done && guard > 2000) begin
                check_output("accept timeout", 32'd0, 32'd1);
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        @(posedge Clk);
        #1;
        frame_start = 1'b0;
    endtask

    task automatic send_header(input logic [3:0] r, input int len, input bit flip, input bit rsv, input bit rv);
        logic [23:0] s;
        s = '0;
        s[0] = r[3];
        s[1] = r[2];
        s[2] = r[1];
        s[3] = r[0];
        s[4] = rsv;
        for (int i = 0; i < 12; i++) s[5+i] = len[i];
        s[17] = (^s[16:0]) ^ flip;
        for (int i = 0; i < 24; i++) apply_stimulus(s[i], rv);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 3000 && data_q.size() != 0; i++) begin
            @(posedge Clk);
            #1;
        end
        check_output("queue drained", 32'(data_q.size()), 32'd0);
        data_q.delete();
        check_output("busy after frame", 32'(busy), 32'd0);
    endtask

    task automatic run_frame(input logic [3:0] r, input int len, input int exp_nsym, input int exp_pads,
                             input bit rv, input bit bp, input int stop_at, input bit by_reset);
        exp_hdr_t h;
        exp_bit_t e;
        int need, ndata;
        bp_mode = bp;
        start_frame();
        send_header(r, len, 1'b0, 1'b0, rv);
        h.nsym = exp_nsym;
        h.pads = exp_pads;
        h.rate = r;
        h.len  = len;
        h.cyc  = last_accept_cyc + exp_nsym + 1;
        hdr_q.push_back(h);
        need  = 22 + 8 * len;
        ndata = need + exp_pads;
        for (int k = 0; k < ndata; k++) begin
            e.b    = 1'($urandom_range(0, 1));
            e.f    = (k < 16) ? 2'd0 : (k < 16 + 8 * len) ? 2'd1 : (k < need) ? 2'd2 : 2'd3;
            e.last = (k == ndata - 1);
            data_q.push_back(e);
            apply_stimulus(e.b, rv);
            if (k == stop_at) begin
                if (by_reset) Reset = 1'b1;
                else abort = 1'b1;
                @(posedge Clk);
                #1;
                Reset = 1'b0;
                abort = 1'b0;
                @(negedge Clk);
                check_output(by_reset ? "busy after reset" : "busy after abort", 32'(busy), 32'd0);
                check_output(by_reset ? "out_valid after reset" : "out_valid after abort", 32'(out_valid), 32'd0);
                check_output("queue after interrupt", 32'(data_q.size()), 32'd0);
                if (by_reset) begin
                    check_output("n_sym after reset", 32'(n_sym), 32'd0);
                    check_output("rate after reset", 32'(rate), 32'd0);
                end
                data_q.delete();
                @(posedge Clk);
                #1;
                return;
            end
        end
        wait_drain();
    endtask

    task automatic err_frame(input logic [3:0] r, input int len, input bit flip, input bit rsv, input logic [1:0] code);
        int np_before;
        bp_mode = 1'b0;
        np_before = np_valid_cnt;
        start_frame();
        err_q.push_back(code);
        send_header(r, len, flip, rsv, 1'b0);
        repeat (6) begin
            @(posedge Clk);
            #1;
        end
        @(negedge Clk);
        check_output("busy after reject", 32'(busy), 32'd0);
        check_output("out_valid after reject", 32'(out_valid), 32'd0);
        check_output("hdr_error seen", 32'(err_q.size()), 32'd0);
        check_output("err_code held", 32'(err_code), 32'(code));
        err_q.delete();
        if (flip) begin
            check_output("no-parity hdr_valid", np_valid_cnt - np_before, 32'd1);
            check_output("no-parity n_sym", 32'(np_n_sym), 32'd2);
            check_output("no-parity num_pads", 32'(np_num_pads), 32'd18);
            @(posedge Clk);
            #1;
            abort = 1'b1;
            @(posedge Clk);
            #1;
            abort = 1'b0;
        end else begin
            @(posedge Clk);
            #1;
        end
    endtask

    initial begin
        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b0;
        @(negedge Clk);
        check_output("reset out_valid", 32'(out_valid), 32'd0);
        check_output("reset in_ready", 32'(in_ready), 32'd0);
        check_output("reset err_code", 32'(err_code), 32'd0);
        check_output("reset rate", 32'(rate), 32'd0);
        check_output("reset length", 32'(length), 32'd0);
        check_output("reset n_sym", 32'(n_sym), 32'd0);
        check_output("reset num_pads", 32'(num_pads), 32'd0);
        check_output("reset busy", 32'(busy), 32'd0);
        @(posedge Clk);
        #1;

        // abort wins over a simultaneous frame_start
        frame_start = 1'b1;
        abort = 1'b1;
        @(posedge Clk);
        #1;
        frame_start = 1'b0;
        abort = 1'b0;
        @(negedge Clk);
        check_output("abort+start busy", 32'(busy), 32'd0);
        check_output("abort+start in_ready", 32'(in_ready), 32'd0);
        @(posedge Clk);
        #1;

        run_frame(4'b1101, 1, 2, 18, 1'b0, 1'b0, -1, 1'b0);
        run_frame(4'b0011, 100, 4, 42, 1'b0, 1'b0, -1, 1'b0);

        err_frame(4'b1101, 1, 1'b1, 1'b0, 2'd1);
        err_frame(4'b0000, 1, 1'b0, 1'b0, 2'd2);
        err_frame(4'b1101, 0, 1'b0, 1'b0, 2'd3);
        err_frame(4'b1101, 1, 1'b0, 1'b1, 2'd3);

        run_frame(4'b0101, 5, 2, 34, 1'b1, 1'b1, -1, 1'b0);
        run_frame(4'b1111, 3, 2, 26, 1'b1, 1'b1, -1, 1'b0);

        run_frame(4'b1001, 2, 1, 58, 1'b0, 1'b0, 20, 1'b0);
        run_frame(4'b1101, 1, 2, 18, 1'b0, 1'b0, -1, 1'b0);
        run_frame(4'b1101, 1, 2, 18, 1'b0, 1'b0, 20, 1'b1);
        run_frame(4'b1011, 10, 1, 42, 1'b0, 1'b0, -1, 1'b0);

        check_output("hdr queue empty", 32'(hdr_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
